// File: rtl/led_arb_pkg.sv
// Shared constants and types for the LED bank arbiter and its round-robin picker.
package led_arb_pkg;

  // FSM encoding kept as plain constants so older tools can read the state vector directly.
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_SHOW = 1'b1;

  // Supported requester counts (power of two only).
  localparam int NREQ_MIN = 32'sd2;
  localparam int NREQ_MAX = 32'sd8;

  // Width of the board LED bank.
  localparam int LED_W = 32'sd8;

  // Index width needed to name any requester at the largest supported count.
  localparam int OWNER_W_MAX = $clog2(NREQ_MAX);

  // Index width for a given requester count; never narrower than one bit.
  function automatic int owner_w(input int nreq);
    return (nreq < 32'sd2) ? 32'sd1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Shared by the arbiters that front other board resources.
module led_rr_pick
  import led_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = owner_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] cand_s;
  logic             hit_s;

  // Scan from the farthest offset down so the closest hit to ptr is the one left standing.
  always_comb begin
    cand_s = {PTR_W{1'b0}};
    hit_s  = 1'b0;
    idx    = {PTR_W{1'b0}};
    any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = ptr + PTR_W'(k);
      hit_s  = req[cand_s];
      idx    = hit_s ? cand_s : idx;
      any    = any | hit_s;
    end
    grant = {{(N-1){1'b0}}, any} << idx;
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Shares the 8-bit LED bank between NREQ requesters with round-robin dwell slots;
// shows a heartbeat on led[0] when nobody owns the bank.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWELL_W   = 24,
  parameter int DWELL_CYC = 12500000,
  parameter int HB_W      = 27
) (
  input  logic                     sys0_clk,
  input  logic                     sys0_rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [LED_W*NREQ-1:0]    req_pattern,
  output logic [NREQ-1:0]          req_ready,
  output logic [LED_W-1:0]         led,
  output logic [$clog2(NREQ)-1:0]  led_owner,
  output logic                     led_busy
);

  localparam int OWN_W = owner_w(NREQ);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYC - 1);

  arb_state_t         state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [HB_W-1:0]    hb_q, hb_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic               busy_q, busy_d;

  logic [NREQ-1:0]    pick_grant_s;
  logic [OWN_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               offer_s;
  logic               xfer_s;
  logic [LED_W-1:0]   pick_pat_s;
  logic [LED_W-1:0]   hb_led_s;

  led_rr_pick #(
    .N     (NREQ),
    .PTR_W (OWN_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Offer window, handshake and the candidate pattern; ready is masked during reset.
  always_comb begin
    offer_s    = (state_q == ST_IDLE) || (dwell_q == {DWELL_W{1'b0}});
    xfer_s     = offer_s & pick_any_s & ~sys0_rst;
    req_ready  = pick_grant_s & {NREQ{offer_s & ~sys0_rst}};
    pick_pat_s = req_pattern[pick_idx_s * LED_W +: LED_W];
  end

  // Next-state logic: grant on transfer, count down the dwell, fall back to the heartbeat.
  always_comb begin
    hb_d     = hb_q + HB_W'(1);
    hb_led_s = {{(LED_W-1){1'b0}}, hb_d[HB_W-1]};
    state_d  = state_q;
    dwell_d  = dwell_q;
    rr_ptr_d = rr_ptr_q;
    led_d    = led_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          state_d  = ST_SHOW;
          dwell_d  = DWELL_LOAD;
          rr_ptr_d = pick_idx_s + OWN_W'(1);
          led_d    = pick_pat_s;
          owner_d  = pick_idx_s;
          busy_d   = 1'b1;
        end else begin
          led_d    = hb_led_s;
        end
      end
      ST_SHOW: begin
        if (dwell_q != {DWELL_W{1'b0}}) begin
          dwell_d  = dwell_q - DWELL_W'(1);
        end else if (xfer_s) begin
          // Seamless handover: the next pattern replaces the current one with no gap.
          dwell_d  = DWELL_LOAD;
          rr_ptr_d = pick_idx_s + OWN_W'(1);
          led_d    = pick_pat_s;
          owner_d  = pick_idx_s;
          busy_d   = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          led_d    = hb_led_s;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = hb_led_s;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) begin
      state_q  <= ST_IDLE;
      dwell_q  <= {DWELL_W{1'b0}};
      hb_q     <= {HB_W{1'b0}};
      rr_ptr_q <= {OWN_W{1'b0}};
      led_q    <= {LED_W{1'b0}};
      owner_q  <= {OWN_W{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      hb_q     <= hb_d;
      rr_ptr_q <= rr_ptr_d;
      led_q    <= led_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
    end
  end

  assign led       = led_q;
  assign led_owner = owner_q;
  assign led_busy  = busy_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter (NREQ=4, DWELL_CYC=4, HB_W=4) plus a DWELL_CYC=1 instance.
module tb_led_bank_arbiter;

  logic        clk;
  logic        rst, rst1;
  logic [3:0]  valid, valid1;
  logic [31:0] pat;
  logic [3:0]  req_ready, ready1;
  logic [7:0]  led, led1;
  logic [1:0]  owner, owner1;
  logic        busy, busy1;

  led_bank_arbiter #(.NREQ(4), .DWELL_W(24), .DWELL_CYC(4), .HB_W(4)) dut (
    .sys0_clk(clk), .sys0_rst(rst), .req_valid(valid), .req_pattern(pat),
    .req_ready(req_ready), .led(led), .led_owner(owner), .led_busy(busy));

  led_bank_arbiter #(.NREQ(4), .DWELL_W(24), .DWELL_CYC(1), .HB_W(4)) dut1 (
    .sys0_clk(clk), .sys0_rst(rst1), .req_valid(valid1), .req_pattern(pat),
    .req_ready(ready1), .led(led1), .led_owner(owner1), .led_busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [1:0] owner;
    logic       busy;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] exp_owner1_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  // Reference model state (DWELL_CYC=4, HB_W=4)
  logic       m_state;
  int         m_dwell;
  logic [3:0] m_hb;
  logic [1:0] m_ptr;
  logic [7:0] m_led;
  logic [1:0] m_owner;
  logic       m_busy;
  logic [3:0] last_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int model_winner();
    int w = -1;
    if (m_state == 1'b0 || m_dwell == 0) begin
      for (int k = 0; k < 4; k++) begin
        int i = (int'(m_ptr) + k) % 4;
        if (w < 0 && valid[i]) w = i;
      end
    end
    return w;
  endfunction

  task automatic model_step();
    logic [3:0] hbn;
    int w;
    if (rst) begin
      m_state = 1'b0; m_dwell = 0; m_hb = 4'd0; m_ptr = 2'd0;
      m_led = 8'h00; m_owner = 2'd0; m_busy = 1'b0;
    end else begin
      hbn = m_hb + 4'd1;
      w = model_winner();
      if (m_state && m_dwell > 0) begin
        m_dwell--;
      end else if (w >= 0) begin
        m_state = 1'b1; m_dwell = 3; m_busy = 1'b1;
        m_led = pat[8*w +: 8]; m_owner = 2'(w); m_ptr = 2'((w + 1) % 4);
      end else begin
        m_state = 1'b0; m_busy = 1'b0; m_led = {7'b0, hbn[3]};
      end
      m_hb = hbn;
    end
  endtask

  // One clock: check ready, advance model, push expectation, compare after the edge.
  task automatic step();
    logic [3:0] er;
    int w;
    exp_t e, o;
    #1;
    w  = model_winner();
    er = (rst || w < 0) ? 4'b0000 : (4'b0001 << w);
    check_eq("req_ready", 32'(req_ready), 32'(er));
    last_ready = req_ready;
    model_step();
    e = '{led: m_led, owner: m_owner, busy: m_busy};
    exp_q.push_back(e);
    @(posedge clk); #1;
    o = exp_q.pop_front();
    check_eq("led", 32'(led), 32'(o.led));
    check_eq("led_owner", 32'(owner), 32'(o.owner));
    check_eq("led_busy", 32'(busy), 32'(o.busy));
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] seen[5];
    logic [7:0] exp_seq[5];
    int gi, odd_grants, busy_gaps, bad_hot;
    bit found;

    rst = 1'b1; rst1 = 1'b1; valid = 4'hF; valid1 = 4'h0;
    pat = {8'h88, 8'h44, 8'h22, 8'h11};
    last_ready = 4'h0;
    @(negedge clk);

    // 1. reset with all requests valid, then first grant goes to requester 0
    step(); step();
    check_eq("t1_rst_led", 32'(led), 32'h0);
    rst = 1'b0;
    step();
    check_eq("t1_first_grant", 32'(last_ready), 32'h1);
    valid = 4'h0;
    repeat (6) step();

    // 2. single request, pattern sampled only at transfer
    pat[7:0] = 8'hA5; valid = 4'b0001;
    step();
    check_eq("t2_ready", 32'(last_ready), 32'h1);
    valid = 4'b0000; pat[7:0] = 8'h5A;
    repeat (3) step();
    check_eq("t2_hold_led", 32'(led), 32'hA5);
    repeat (3) step();
    check_eq("t2_busy_off", 32'(busy), 32'h0);

    // 3. all valid after reset: 0x11,0x22,0x44,0x88,0x11 with no gaps
    pat = {8'h88, 8'h44, 8'h22, 8'h11};
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h44;
    exp_seq[3] = 8'h88; exp_seq[4] = 8'h11;
    rst = 1'b1; step(); rst = 1'b0;
    valid = 4'hF;
    gi = 0; busy_gaps = 0; bad_hot = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (last_ready != 4'h0) begin
        if ($countones(last_ready) != 1) bad_hot++;
        if (gi < 5) seen[gi] = led;
        gi++;
      end
      if (!busy) busy_gaps++;
    end
    check_eq("t3_grants", 32'(gi), 32'd5);
    check_eq("t3_gaps", 32'(busy_gaps), 32'd0);
    check_eq("t3_onehot", 32'(bad_hot), 32'd0);
    for (int i = 0; i < 5; i++) check_eq("t3_seq", 32'(seen[i]), 32'(exp_seq[i]));

    // 4. fairness with req0 and req2 only
    valid = 4'b0101; odd_grants = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (last_ready[1] || last_ready[3]) odd_grants++;
    end
    check_eq("t4_odd_grants", 32'(odd_grants), 32'd0);

    // 5. reset while owner 1 is mid-dwell
    valid = 4'b0000; repeat (6) step();
    valid = 4'b0011; found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (busy && owner == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t5_owner1_seen", 32'(found), 32'd1);
    step();
    rst = 1'b1; step();
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_led", 32'(led), 32'd0);
    rst = 1'b0; step();
    check_eq("t5_first_owner", 32'(owner), 32'd0);

    // 6. idle heartbeat
    valid = 4'b0000;
    repeat (24) step();
    check_eq("t6_upper_zero", 32'(led[7:1]), 32'd0);

    // 6b. DWELL_CYC=1, all valid: owner advances every cycle
    valid1 = 4'hF; @(posedge clk); #1; @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_owner1_q.push_back(2'(i % 4));
      @(posedge clk); #1;
      check_eq("t6_d1_owner", 32'(owner1), 32'(exp_owner1_q.pop_front()));
      check_eq("t6_d1_busy", 32'(busy1), 32'd1);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
